// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered MUL/DIV results.
// Optional macro WB_ANTI_STARVE_EN forces a FIFO drain after STARVE_LIMIT waiting cycles.
module wb_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_wen,
    input  logic [4:0]               pipe_rd_addr,
    input  logic [31:0]              pipe_rd_data,
    input  logic                     mdu_valid,
    output logic                     mdu_ready,
    input  logic [4:0]               mdu_rd_addr,
    input  logic [31:0]              mdu_rd_data,
    output logic                     rf_wen,
    output logic [4:0]               rf_rd_addr,
    output logic [31:0]              rf_rd_data,
    output logic [31:0]              pending_mask,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     stall_req
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT == 0) begin : g_param_check
        $error("wb_arbiter: DEPTH must be a power of two >= 2 and STARVE_LIMIT > 0");
    end

    logic [4:0]       q_addr [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [DEPTH-1:0] q_live;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic fifo_empty_c;
    logic pipe_req_c;
    logic pop_c;
    logic push_c;

    // Arbitration: pipe first unless a forced drain is pending, then FIFO head.
    always_comb begin
        fifo_empty_c = (fifo_count == '0);
        mdu_ready    = (fifo_count != CNT_W'(DEPTH));
        pipe_req_c   = pipe_wen && (pipe_rd_addr != 5'd0) && !stall_req;
        pop_c        = !pipe_req_c && !fifo_empty_c;
        push_c       = mdu_valid && mdu_ready && (mdu_rd_addr != 5'd0);
    end

    // Payload storage; only the live bits need reset.
    always_ff @(posedge clk) begin
        if (!rst && push_c) begin
            q_addr[wr_ptr] <= mdu_rd_addr;
            q_data[wr_ptr] <= mdu_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_live     <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            rf_wen     <= 1'b0;
            rf_rd_addr <= 5'd0;
            rf_rd_data <= 32'd0;
        end else begin
            // WAW squash: the pipe write is younger than every queued entry.
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (pipe_req_c && q_live[i] && (q_addr[i] == pipe_rd_addr)) begin
                    q_live[i] <= 1'b0;
                end
            end
            if (pop_c) begin
                q_live[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + PTR_W'(1);
            end
            // Placed after the squash so a same-cycle push to the same register stays live.
            if (push_c) begin
                q_live[wr_ptr] <= 1'b1;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase

            if (pipe_req_c) begin
                rf_wen     <= 1'b1;
                rf_rd_addr <= pipe_rd_addr;
                rf_rd_data <= pipe_rd_data;
            end else if (pop_c) begin
                rf_wen <= q_live[rd_ptr];
                if (q_live[rd_ptr]) begin
                    rf_rd_addr <= q_addr[rd_ptr];
                    rf_rd_data <= q_data[rd_ptr];
                end
            end else begin
                rf_wen <= 1'b0;
            end
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (q_live[i]) begin
                pending_mask[q_addr[i]] = 1'b1;
            end
        end
        pending_mask[0] = 1'b0;
    end

`ifdef WB_ANTI_STARVE_EN
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_cnt_next_c;

    // Counts cycles a non-empty FIFO is passed over; saturates at the limit.
    always_comb begin
        starve_cnt_next_c = starve_cnt;
        if (fifo_empty_c || pop_c) begin
            starve_cnt_next_c = '0;
        end else if (starve_cnt < SW'(STARVE_LIMIT)) begin
            starve_cnt_next_c = starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            starve_cnt <= starve_cnt_next_c;
            stall_req  <= (starve_cnt_next_c >= SW'(STARVE_LIMIT));
        end
    end
`else
    assign stall_req = 1'b0;
`endif

endmodule
